graph_rsqrt_stream_fp16: RTL and testbench



---
 rtl/graph_rsqrt_stream_fp16.sv | 153 +++++++++++++++
 tb/tb_graph_rsqrt_stream_fp16.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/graph_rsqrt_stream_fp16.sv
// rtl/graph_rsqrt_stream_fp16.sv - command-framed FP16 stream sequencer in front of a registered rsqrt ROM LUT
// Optional build macro: GRAPH_RSQRT_SAT_EN (saturate +Inf/NaN LUT results on the FIFO write path)
module graph_rsqrt_stream_fp16 #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic [7:0]       lut_addr,
    input  logic [15:0]      lut_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_last,
    output logic             special_seen
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE_S} state_t;

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic [15:0]      mem_data [FIFO_DEPTH];
    logic             mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;
    logic             inflight;
    logic             inflight_last;
    logic             in_fire;
    logic             pop;
    logic             raw_special;
    logic [15:0]      wr_data;
    logic             unused_low;

    assign lut_addr   = in_data[15:8];
    assign unused_low = ^in_data[7:0];

    // A LUT read in flight reserves a FIFO slot, so the FIFO can never overflow.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
    assign in_ready  = (state == RUN) && (remaining != '0)
                       && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign in_fire   = in_valid && in_ready;

    assign out_valid = (fifo_count != '0);
    assign out_data  = mem_data[rd_ptr];
    assign out_last  = mem_last[rd_ptr];
    assign pop       = out_valid && out_ready;

    assign raw_special = (lut_data == 16'h7C00) || (lut_data == 16'h7E00);

    always_comb begin
        wr_data = lut_data;
`ifdef GRAPH_RSQRT_SAT_EN
        if (lut_data == 16'h7C00) begin
            wr_data = 16'h7BFF;
        end else if (lut_data == 16'h7E00) begin
            wr_data = 16'h0000;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            remaining     <= '0;
            special_seen  <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        special_seen <= 1'b0;
                        remaining    <= len;
                        busy         <= 1'b1;
                        if (len == '0) begin
                            state <= DONE_S;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Popping the last-tagged entry implies the FIFO is empty and nothing is in flight.
                    if (pop && out_last) begin
                        state <= DONE_S;
                        done  <= 1'b1;
                    end
                end
                DONE_S: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            inflight      <= in_fire;
            inflight_last <= in_fire && (remaining == LEN_W'(1));
            if (inflight && raw_special) begin
                special_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
            end
        end else begin
            if (inflight) begin
                mem_data[wr_ptr] <= wr_data;
                mem_last[wr_ptr] <= inflight_last;
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({inflight, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_graph_rsqrt_stream_fp16.sv
// tb/tb_graph_rsqrt_stream_fp16.sv - vector table, hand sequences and random commands against a reference model
module tb_graph_rsqrt_stream_fp16;

    localparam int DEPTH = 4;

`ifdef GRAPH_RSQRT_SAT_EN
    localparam logic [15:0] E_INF = 16'h7BFF;
    localparam logic [15:0] E_NAN = 16'h0000;
`else
    localparam logic [15:0] E_INF = 16'h7C00;
    localparam logic [15:0] E_NAN = 16'h7E00;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic        busy, done, in_ready, out_valid, out_last, special_seen;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [7:0]  lut_addr;
    logic [15:0] lut_data = '0;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;

    int total = 0;
    int bad = 0;

    graph_rsqrt_stream_fp16 #(.FIFO_DEPTH(DEPTH), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .lut_addr(lut_addr), .lut_data(lut_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .special_seen(special_seen)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lut_fn(input logic [7:0] a);
        case (a)
            8'h3C:   lut_fn = 16'h3C00;
            8'h40:   lut_fn = 16'h39A8;
            8'h44:   lut_fn = 16'h3800;
            8'h48:   lut_fn = 16'h35A8;
            8'h4C:   lut_fn = 16'h3400;
            8'h38:   lut_fn = 16'h3DA8;
            8'h34:   lut_fn = 16'h4000;
            8'h30:   lut_fn = 16'h41A8;
            8'h00:   lut_fn = 16'h7C00;
            8'hBC:   lut_fn = 16'h7E00;
            8'h7C:   lut_fn = 16'h0000;
            default: lut_fn = {~a, a};
        endcase
    endfunction

    // Registered ROM: data for an address appears one clock later.
    always @(posedge clk) lut_data <= lut_fn(lut_addr);

    function automatic logic [15:0] model_out(input logic [15:0] x);
        logic [15:0] r;
        r = lut_fn(x[15:8]);
`ifdef GRAPH_RSQRT_SAT_EN
        if (r == 16'h7C00) r = 16'h7BFF;
        else if (r == 16'h7E00) r = 16'h0000;
`endif
        return r;
    endfunction

    function automatic bit model_special(input logic [15:0] x);
        logic [15:0] r;
        r = lut_fn(x[15:8]);
        return (r == 16'h7C00) || (r == 16'h7E00);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Overflow guard on the DUT's buffer occupancy.
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (int'(dut.fifo_count) + int'(dut.inflight) > DEPTH) begin
                bad++;
                $display("FAIL fifo_overflow: occupancy=%0d limit=%0d",
                         int'(dut.fifo_count) + int'(dut.inflight), DEPTH);
            end
        end
    end

    logic [15:0] cmd_din [32];
    logic [15:0] cmd_exp [32];

    task automatic check_reset_vals(input string nm);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_in_ready"}, 32'(in_ready), 0);
        chk({nm, "_out_valid"}, 32'(out_valid), 0);
        chk({nm, "_out_data"}, 32'(out_data), 0);
        chk({nm, "_out_last"}, 32'(out_last), 0);
        chk({nm, "_special"}, 32'(special_seen), 0);
    endtask

    // rmode: 0 = always valid/ready, 1 = out_ready low for 'hold' cycles, 2 = random valid/ready
    task automatic run_cmd(input string nm, input int n, input int rmode, input int hold,
                           input bit inj, input bit exp_spec);
        int cyc, idx_in, idx_out, first_hs, first_out, last_out, hs_before_hold;
        bit done_seen, prev_stall, any_in_ready, any_out_valid;
        logic [15:0] prev_data;
        logic prev_last;
        @(posedge clk); #1;
        start = 1'b1; len = 16'(n); in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; idx_in = 0; idx_out = 0; first_hs = -1; first_out = -1; last_out = -1;
        hs_before_hold = 0; done_seen = 0; prev_stall = 0; any_in_ready = 0; any_out_valid = 0;
        prev_data = '0; prev_last = 1'b0;
        while (!done_seen && cyc < 2000) begin
            in_valid = (idx_in < n) && ((rmode != 2) || ($urandom_range(0, 3) != 0));
            in_data = (idx_in < n) ? cmd_din[idx_in] : 16'(cyc * 16'h0101);
            out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc >= hold) : 1'($urandom_range(0, 1));
            start = inj && (cyc == 1);
            if (inj && cyc == 1) len = 16'(n + 2);
            @(negedge clk);
            if (in_ready) any_in_ready = 1;
            if (out_valid) begin
                any_out_valid = 1;
                if (first_out < 0) first_out = cyc;
            end
            if (prev_stall) begin
                chk({nm, "_stall_data"}, 32'(out_data), 32'(prev_data));
                chk({nm, "_stall_last"}, 32'(out_last), 32'(prev_last));
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (in_valid && in_ready) begin
                if (first_hs < 0) first_hs = cyc;
                if (rmode == 1 && cyc < hold) hs_before_hold++;
                idx_in++;
            end
            if (out_valid && out_ready) begin
                if (idx_out < n) begin
                    chk($sformatf("%s_data%0d", nm, idx_out), 32'(out_data), 32'(cmd_exp[idx_out]));
                    chk($sformatf("%s_last%0d", nm, idx_out), 32'(out_last), 32'(idx_out == n - 1));
                end else begin
                    chk({nm, "_extra_output"}, 32'(idx_out), 32'(n));
                end
                idx_out++;
                last_out = cyc;
            end
            if (done) begin
                done_seen = 1;
                chk({nm, "_busy_at_done"}, 32'(busy), 1);
                chk({nm, "_count"}, 32'(idx_out), 32'(n));
                chk({nm, "_special"}, 32'(special_seen), 32'(exp_spec));
                if (n > 0) chk({nm, "_done_lat"}, 32'(cyc), 32'(last_out + 1));
                else chk({nm, "_len0_done_cyc"}, 32'(cyc), 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0;
        if (!done_seen) begin
            bad++;
            $display("FAIL %s_timeout: done not seen after %0d cycles", nm, cyc);
        end
        if (n == 0) begin
            chk({nm, "_len0_in_ready"}, 32'(any_in_ready), 0);
            chk({nm, "_len0_out_valid"}, 32'(any_out_valid), 0);
        end
        if (rmode == 0 && n > 0) begin
            chk({nm, "_first_latency"}, 32'(first_out - first_hs), 2);
            chk({nm, "_throughput"}, 32'(last_out - first_out), 32'(n - 1));
        end
        if (rmode == 1) chk({nm, "_accepted_while_held"}, 32'(hs_before_hold), DEPTH);
        @(negedge clk);
        chk({nm, "_idle_busy"}, 32'(busy), 0);
        chk({nm, "_idle_done"}, 32'(done), 0);
    endtask

    typedef struct {
        string       nm;
        int          n;
        int          rmode;
        int          hold;
        bit          inj;
        bit          spec;
        logic [15:0] din [8];
        logic [15:0] dout [8];
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{"basic", 4, 0, 0, 1'b0, 1'b0,
                    '{16'h3C00, 16'h4000, 16'h4400, 16'h3C55, 0, 0, 0, 0},
                    '{16'h3C00, 16'h39A8, 16'h3800, 16'h3C00, 0, 0, 0, 0}};
        vecs[1] = '{"special", 3, 0, 0, 1'b0, 1'b1,
                    '{16'h0000, 16'hBC00, 16'h7C00, 0, 0, 0, 0, 0},
                    '{E_INF, E_NAN, 16'h0000, 0, 0, 0, 0, 0}};
        vecs[2] = '{"backpressure", 8, 1, 10, 1'b0, 1'b0,
                    '{16'h3C00, 16'h4000, 16'h4400, 16'h4800, 16'h4C00, 16'h3800, 16'h3400, 16'h3000},
                    '{16'h3C00, 16'h39A8, 16'h3800, 16'h35A8, 16'h3400, 16'h3DA8, 16'h4000, 16'h41A8}};
        vecs[3] = '{"len0", 0, 0, 0, 1'b0, 1'b0,
                    '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[4] = '{"start_in_run", 5, 2, 0, 1'b1, 1'b0,
                    '{16'h3000, 16'h3400, 16'h3800, 16'h3C00, 16'h4000, 0, 0, 0},
                    '{16'h41A8, 16'h4000, 16'h3DA8, 16'h3C00, 16'h39A8, 0, 0, 0}};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 8; i++) begin
                cmd_din[i] = vecs[v].din[i];
                cmd_exp[i] = vecs[v].dout[i];
            end
            run_cmd(vecs[v].nm, vecs[v].n, vecs[v].rmode, vecs[v].hold, vecs[v].inj, vecs[v].spec);
        end

        // Reset with results buffered mid-command, then a fresh one-element command.
        @(posedge clk); #1;
        start = 1'b1; len = 16'd6; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 16'h0000;
        @(posedge clk); #1;
        in_data = 16'h4000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midreset_pre_valid", 32'(out_valid), 1);
        chk("midreset_pre_special", 32'(special_seen), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("midreset");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("midreset_no_done%0d", k), 32'(done), 0);
        end
        cmd_din[0] = 16'h4400;
        cmd_exp[0] = 16'h3800;
        run_cmd("after_reset", 1, 0, 0, 1'b0, 1'b0);

        // Random commands against the reference model.
        for (int r = 0; r < 8; r++) begin
            int n;
            bit sp;
            n = $urandom_range(1, 20);
            sp = 0;
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 7))
                    0:       cmd_din[i] = {8'h00, 8'($urandom)};
                    1:       cmd_din[i] = {8'hBC, 8'($urandom)};
                    2:       cmd_din[i] = {8'h7C, 8'($urandom)};
                    default: cmd_din[i] = 16'($urandom);
                endcase
                cmd_exp[i] = model_out(cmd_din[i]);
                sp = sp | model_special(cmd_din[i]);
            end
            run_cmd($sformatf("rand%0d", r), n, 2, 0, 1'b0, sp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
